// File: rtl/prog_lut.sv
// Programmable N_IN-input lookup table with serial truth-table reload.
// Define PROG_LUT_IN_SYNC_EN to add a 2-flop input synchronizer.
module prog_lut #(
  parameter int                  N_IN    = 3,
  parameter logic [2**N_IN-1:0]  TT_INIT = 8'h70
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_valid,
  output logic            out,
  output logic            out_valid,
  input  logic            cfg_start,
  input  logic            cfg_bit,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic            cfg_done
);

  localparam int DEPTH = 2**N_IN;
  localparam int CW    = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  cfg_state_e       state;
  cfg_state_e       state_nxt;
  logic [DEPTH-1:0] tt;
  logic [DEPTH-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic             xfer;
  logic             last;
  logic             clr;
  logic [N_IN-1:0]  ev_vec;
  logic             ev_valid;

  assign xfer = cfg_valid && cfg_ready && !cfg_start;
  assign last = (cnt == CW'(DEPTH - 1));
  assign clr  = cfg_start && (state != COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cfg_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (xfer && last) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    unique case (state)
      SHIFT:   cfg_ready = 1'b1;
      COMMIT:  cfg_done  = 1'b1;
      default: ;
    endcase
  end

  // shadow collects the new table; the live table swaps only in COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt     <= TT_INIT;
      shadow <= '0;
      cnt    <= '0;
    end else begin
      if (state == COMMIT) tt <= shadow;
      if (clr) begin
        shadow <= '0;
        cnt    <= '0;
      end else if (xfer) begin
        shadow[cnt[N_IN-1:0]] <= cfg_bit;
        cnt                   <= cnt + CW'(1);
      end
    end
  end

`ifdef PROG_LUT_IN_SYNC_EN
  logic [N_IN-1:0] s1_vec;
  logic [N_IN-1:0] s2_vec;
  logic            s1_valid;
  logic            s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vec   <= '0;
      s2_vec   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_vec   <= in_vec;
      s2_vec   <= s1_vec;
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  assign ev_vec   = s2_vec;
  assign ev_valid = s2_valid;
`else
  assign ev_vec   = in_vec;
  assign ev_valid = in_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= ev_valid;
      if (ev_valid) out <= tt[ev_vec];
    end
  end

endmodule

// File: tb/tb_prog_lut.sv
// Self-checking bench for prog_lut (N_IN=3, TT_INIT=8'h70).
// Queue-based table-load model plus directed literal checks.
module tb_prog_lut;

`ifdef PROG_LUT_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_vec = '0;
  logic       in_valid = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       out;
  logic       out_valid;
  logic       cfg_ready;
  logic       cfg_done;

  prog_lut #(.N_IN(3), .TT_INIT(8'h70)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .cfg_start (cfg_start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  bit [7:0] m_tt = 8'h70;
  bit [7:0] m_pend = 8'h00;
  bit       m_bits[$];
  bit       m_load = 1'b0;
  bit       m_commit = 1'b0;
  bit       e_out = 1'b0;
  bit       e_ov = 1'b0;
  bit       p1_v = 1'b0;
  bit       p2_v = 1'b0;
  bit [2:0] p1_x = '0;
  bit [2:0] p2_x = '0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    m_tt = 8'h70;
    m_bits.delete();
    m_load = 1'b0;
    m_commit = 1'b0;
    e_out = 1'b0;
    e_ov = 1'b0;
    p1_v = 1'b0;
    p2_v = 1'b0;
    p1_x = '0;
    p2_x = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit       v;
      bit [2:0] x;
`ifdef PROG_LUT_IN_SYNC_EN
      v = p2_v;
      x = p2_x;
      p2_v = p1_v;
      p2_x = p1_x;
      p1_v = in_valid;
      p1_x = in_vec;
`else
      v = in_valid;
      x = in_vec;
`endif
      e_ov = v;
      if (v) e_out = m_tt[x];
      if (m_commit) begin
        m_tt = m_pend;
        m_commit = 1'b0;
      end else if (m_load) begin
        if (cfg_start) begin
          m_bits.delete();
        end else if (cfg_valid) begin
          m_bits.push_back(cfg_bit);
          if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) m_pend[i] = m_bits[i];
            m_load = 1'b0;
            m_commit = 1'b1;
          end
        end
      end else if (cfg_start) begin
        m_load = 1'b1;
        m_bits.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m_out_valid", int'(out_valid), int'(e_ov));
      chk("m_out", int'(out), int'(e_out));
      chk("m_cfg_ready", int'(cfg_ready), int'(m_load));
      chk("m_cfg_done", int'(cfg_done), int'(m_commit));
      if (cfg_done) done_cnt++;
    end
  end

  task automatic eval1(input logic [2:0] v, input bit exp, input string nm);
    in_vec = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk({nm, "_ov"}, int'(out_valid), 1);
    chk(nm, int'(out), int'(exp));
  endtask

  task automatic sweep(input bit [7:0] exp_tt, input string nm);
    for (int i = 0; i < 8; i++)
      eval1(3'(i), exp_tt[i], $sformatf("%s_%0d", nm, i));
  endtask

  task automatic load(input bit [7:0] val, input int gap_at);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        cfg_valid = 1'b0;
        cfg_bit = ~val[i];
        @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_bit = val[i];
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk("load_done_lit", int'(cfg_done), 1);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_cfg_done", int'(cfg_done), 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    sweep(8'h70, "init");

    cfg_valid = 1'b1;
    cfg_bit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    load(8'h96, 3);
    sweep(8'h96, "t96");

    in_vec = 3'd4;
    in_valid = 1'b1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b0;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
`ifndef PROG_LUT_IN_SYNC_EN
    chk("ovl_done", int'(cfg_done), 1);
    chk("ovl_pre", int'(out), 1);
    @(negedge clk);
    chk("ovl_commit", int'(out), 1);
    @(negedge clk);
    chk("ovl_new", int'(out), 0);
`else
    repeat (2) @(negedge clk);
`endif
    in_valid = 1'b0;
    repeat (LAT) @(negedge clk);

    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cfg_ready", int'(cfg_ready), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out", int'(out), 0);
    cfg_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    eval1(3'd5, 1'b1, "arst_tt5");
    eval1(3'd3, 1'b0, "arst_tt3");

    d0 = done_cnt;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b0;
      @(negedge clk);
    end
    cfg_start = 1'b1;
    cfg_bit = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    chk("restart_one_done", done_cnt - d0, 1);
    chk("commit_start_ign", int'(cfg_ready), 0);
    sweep(8'hFF, "tff");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
